map_port_arbiter: RTL and testbench
===================================

Name: map_port_arbiter

Overview:
- Shares the minimap read port (port B) of the map BRAM between two kinds of user: the minimap renderer and terrain lookups from the P1/P2 physics engines (track/grass checks at the car position).
- The renderer always wins and sees zero added latency. Physics queries are served round-robin in cycles when the renderer does not need the port, using a req/ack/rvalid handshake.
- Sits between the pixel datapath and blk_mem_gen_0 port B and runs in the 25 MHz pixel clock domain.

Parameters:
- ADDR_W, 17, BRAM address width
- DATA_W, 4, BRAM colour-index width
- MAP_WIDTH, 320, map width in world pixels
- MAP_HEIGHT, 240, map height in world pixels
- BASE_ADDR, 0, offset added to every physics-query address
- READ_LATENCY, 1, BRAM read latency in cycles (1..3)
- OOB_INDEX, 4'hF, index returned for out-of-map queries
- STARVE_LIMIT, 1023, wait cycles before a pending request is flagged as starved

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  reset, asynchronous, active-low
- rnd_en  in  1  renderer needs the port this cycle
- rnd_addr  in  ADDR_W  renderer address
- p1_req  in  1  P1 terrain query request
- p1_x  in  10  P1 query world x
- p1_y  in  10  P1 query world y
- p1_ack  out  1  P1 request accepted (1-cycle pulse)
- p1_rvalid  out  1  P1 result valid (1-cycle pulse)
- p1_rdata  out  DATA_W  P1 result; held until the next p1_rvalid
- p2_req, p2_x, p2_y, p2_ack, p2_rvalid, p2_rdata: same as P1
- bram_addr  out  ADDR_W  to BRAM port B addrb
- bram_dout  in  DATA_W  from BRAM port B doutb
- starve_flag  out  2  sticky flags: bit0 = P1 starved, bit1 = P2 starved

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- Reset values:
  - all ack and rvalid outputs 0
  - p1_rdata and p2_rdata 0
  - starve_flag 0
  - result pipeline empty
  - round-robin pointer last_grant = P2, so P1 is favoured first
- bram_addr is a combinational mux:
  - rnd_en=1: rnd_addr in the same cycle.
  - Otherwise, the address of the request granted this cycle.
  - No grant: 0.
- Address computation:
  - addr = BASE_ADDR + (y<<8) + (y<<6) + x, computed in ADDR_W bits.
  - No multiplier is used.
- Out-of-bounds queries:
  - A query is OOB when x >= MAP_WIDTH or y >= MAP_HEIGHT.
  - An OOB query does not need the port, so it may be granted while rnd_en=1. Its result is OOB_INDEX.
- Arbitration, evaluated once per cycle; at most one ack per cycle:
  - Eligible requester: req=1, and (rnd_en=0 or query is OOB).
  - One eligible requester: it is granted.
  - Both eligible: the requester that is not last_grant is granted.
  - last_grant updates on every grant.
- Handshake:
  - A requester holds req, x and y stable until ack.
  - ack is asserted combinationally in the grant cycle, and x/y are sampled in that cycle.
  - If req is still high in the cycle after ack, it is a new request.
  - If req drops before ack, the request is withdrawn: no ack, no rvalid.
- Result pipeline:
  - A tag shift register of depth READ_LATENCY carries {valid, id, oob} per stage.
  - rvalid for the requester pulses exactly READ_LATENCY cycles after its ack.
  - At that cycle, rdata is loaded from bram_dout, or from OOB_INDEX when the tag's oob bit is set.
  - Back-to-back grants on consecutive cycles produce back-to-back rvalids in grant order.
- Renderer:
  - The renderer is never stalled or delayed.
  - While rnd_en=1, in-bounds physics requests wait.
  - Normal VGA blanking (160 of 800 cycles per line, and full lines during vblank) guarantees service.
- Starvation:
  - A per-requester 10-bit wait counter increments each cycle req=1 without ack.
  - It clears on ack or when req=0.
  - When the counter reaches STARVE_LIMIT, the corresponding starve_flag bit sets and stays set until reset. The counter saturates.
- Reset mid-operation: the pipeline is flushed; no rvalid is emitted for requests acked before reset.

Test Plan:
- Reset, then p1_req with (15,125) and rnd_en=0:
  - p1_ack in the same cycle.
  - bram_addr = 125*320+15 = 40015.
  - p1_rvalid 1 cycle later; p1_rdata = bram_dout.
- p1_req and p2_req held high together, rnd_en=0, for 4 grants:
  - Acks alternate P1, P2, P1, P2.
  - rvalids follow in the same order, each 1 cycle after its ack.
- rnd_en=1 with rnd_addr=17'd500, p2_req in-bounds:
  - bram_addr = 500 throughout.
  - No p2_ack until rnd_en drops; p2_ack in the first cycle with rnd_en=0.
- p1_req with (320,10) while rnd_en=1:
  - Immediate p1_ack.
  - p1_rvalid next cycle with p1_rdata = 4'hF.
  - bram_addr stays equal to rnd_addr.
- rnd_en held at 1, p2_req in-bounds held for 1023 cycles:
  - starve_flag = 2'b10.
  - The flag stays set after rnd_en drops and the request is served.
- rst asserted low the cycle after p1_ack:
  - No p1_rvalid.
  - All outputs 0.
  - After release, P1 wins the first simultaneous request.

Source files
------------

// File: rtl/map_port_if.sv
// map_port_if: renderer, physics-query and BRAM port B signals of the map port arbiter
interface map_port_if #(parameter int ADDR_W = 17, parameter int DATA_W = 4);
  logic              rnd_en;
  logic [ADDR_W-1:0] rnd_addr;
  logic              p1_req, p2_req;
  logic [9:0]        p1_x, p1_y, p2_x, p2_y;
  logic              p1_ack, p2_ack, p1_rvalid, p2_rvalid;
  logic [DATA_W-1:0] p1_rdata, p2_rdata;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [1:0]        starve_flag;
  modport master (
    output rnd_en, rnd_addr, p1_req, p1_x, p1_y, p2_req, p2_x, p2_y, bram_dout,
    input  p1_ack, p2_ack, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, bram_addr, starve_flag
  );
  modport slave (
    input  rnd_en, rnd_addr, p1_req, p1_x, p1_y, p2_req, p2_x, p2_y, bram_dout,
    output p1_ack, p2_ack, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata, bram_addr, starve_flag
  );
endinterface

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares map BRAM port B between the minimap renderer and two physics terrain queries
module map_port_arbiter #(
  parameter int                ADDR_W       = 17,
  parameter int                DATA_W       = 4,
  parameter int                MAP_WIDTH    = 320,
  parameter int                MAP_HEIGHT   = 240,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] OOB_INDEX    = 4'hF,
  parameter int                STARVE_LIMIT = 1023
) (
  input logic       clk,
  input logic       rst,
  map_port_if.slave bus
);
  logic [1:0]              req, oob, elig, grant, vld, flag;
  logic [9:0]              qx [2];
  logic [9:0]              qy [2];
  logic [ADDR_W-1:0]       qa [2];
  logic [9:0]              wait_cnt [2];
  logic [DATA_W-1:0]       hold [2];
  logic                    last_p2;
  logic [READ_LATENCY-1:0] tv, tid, toob;
  logic [DATA_W-1:0]       res;
  for (genvar i = 0; i < 2; i++) begin : g_q
    assign req[i]  = i ? bus.p2_req : bus.p1_req;
    assign qx[i]   = i ? bus.p2_x : bus.p1_x;
    assign qy[i]   = i ? bus.p2_y : bus.p1_y;
    assign oob[i]  = int'(qx[i]) >= MAP_WIDTH || int'(qy[i]) >= MAP_HEIGHT;
    // y*320 as two shifts so no multiplier is inferred
    assign qa[i]   = BASE_ADDR + (ADDR_W'(qy[i]) << 8) + (ADDR_W'(qy[i]) << 6) + ADDR_W'(qx[i]);
    assign elig[i] = req[i] && (!bus.rnd_en || oob[i]);
  end
  assign grant[0] = elig[0] && (!elig[1] || last_p2);
  assign grant[1] = elig[1] && (!elig[0] || !last_p2);
  assign bus.p1_ack = grant[0];
  assign bus.p2_ack = grant[1];
  assign bus.bram_addr = bus.rnd_en ? bus.rnd_addr : grant[0] ? qa[0] : grant[1] ? qa[1] : '0;
  assign vld = {tv[READ_LATENCY-1] & tid[READ_LATENCY-1], tv[READ_LATENCY-1] & ~tid[READ_LATENCY-1]};
  assign res = toob[READ_LATENCY-1] ? OOB_INDEX : bus.bram_dout;
  assign bus.p1_rvalid = vld[0];
  assign bus.p2_rvalid = vld[1];
  assign bus.p1_rdata = vld[0] ? res : hold[0];
  assign bus.p2_rdata = vld[1] ? res : hold[1];
  assign bus.starve_flag = flag;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tv      <= '0;
      tid     <= '0;
      toob    <= '0;
      last_p2 <= 1'b1;
    end else begin
      for (int k = READ_LATENCY - 1; k > 0; k--) begin
        tv[k]   <= tv[k-1];
        tid[k]  <= tid[k-1];
        toob[k] <= toob[k-1];
      end
      tv[0]   <= |grant;
      tid[0]  <= grant[1];
      toob[0] <= grant[1] ? oob[1] : oob[0];
      if (|grant) last_p2 <= grant[1];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      flag <= '0;
      for (int j = 0; j < 2; j++) begin
        hold[j]     <= '0;
        wait_cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (vld[j]) hold[j] <= res;
        wait_cnt[j] <= (req[j] && !grant[j]) ? wait_cnt[j] + {9'd0, ~&wait_cnt[j]} : '0;
        if (req[j] && !grant[j] && {1'b0, wait_cnt[j]} + 11'd1 >= 11'(STARVE_LIMIT)) flag[j] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: vector table, corner sequences and randomized checking against a reference model
module tb_map_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  map_port_if #(.ADDR_W(17), .DATA_W(4)) bus();
  map_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  int ncmp = 0;
  int nerr = 0;
  typedef struct {
    bit re; int ra;
    bit r1; int x1; int y1;
    bit r2; int x2; int y2;
    bit a1; bit a2; int addr;
  } vec_t;
  vec_t tv [11];
  function automatic logic [3:0] mem_f(logic [16:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction
  function automatic int qaddr(int x, int y);
    return (y * 320 + x) % 131072;
  endfunction
  function automatic bit is_oob(int x, int y);
    return x >= 320 || y >= 240;
  endfunction
  function automatic int exp_data(int x, int y);
    return is_oob(x, y) ? 15 : int'(mem_f(17'(qaddr(x, y))));
  endfunction
  always @(posedge clk) bus.bram_dout <= mem_f(bus.bram_addr);
  task automatic chk(string n, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(bit re, int ra, bit r1, int x1, int y1, bit r2, int x2, int y2);
    bus.rnd_en = re; bus.rnd_addr = 17'(ra);
    bus.p1_req = r1; bus.p1_x = 10'(x1); bus.p1_y = 10'(y1);
    bus.p2_req = r2; bus.p2_x = 10'(x2); bus.p2_y = 10'(y2);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {bus.p1_ack, bus.p2_ack}, 0);
    chk("rst_rvalid", {bus.p1_rvalid, bus.p2_rvalid}, 0);
    chk("rst_rdata", {bus.p1_rdata, bus.p2_rdata}, 0);
    chk("rst_starve", bus.starve_flag, 0);
    rst = 1'b1;
  endtask
  // random-phase reference model state
  int lg, win, eaddr;
  bit pv [2];
  int pd [2];
  int held [2];
  int wcnt [2];
  bit mflag [2];
  bit rq [2];
  bit acked [2];
  int rx [2];
  int ry [2];
  bit el [2];
  bit re;
  int ra;
  initial begin
    tv[0]  = '{0, 0,   1, 15, 125, 0, 0, 0,     1, 0, 40015};
    tv[1]  = '{0, 0,   1, 1, 1,    1, 2, 2,     0, 1, 642};
    tv[2]  = '{0, 0,   1, 1, 1,    1, 2, 2,     1, 0, 321};
    tv[3]  = '{1, 500, 0, 0, 0,    1, 5, 5,     0, 0, 500};
    tv[4]  = '{1, 500, 1, 320, 10, 1, 5, 5,     1, 0, 500};
    tv[5]  = '{0, 0,   0, 0, 0,    1, 5, 5,     0, 1, 1605};
    tv[6]  = '{0, 0,   0, 0, 0,    0, 0, 0,     0, 0, 0};
    tv[7]  = '{0, 0,   0, 0, 0,    1, 319, 239, 0, 1, 76799};
    tv[8]  = '{1, 9,   1, 400, 0,  1, 0, 300,   1, 0, 9};
    tv[9]  = '{0, 0,   1, 7, 3,    0, 0, 0,     1, 0, 967};
    tv[10] = '{0, 0,   0, 0, 0,    0, 0, 0,     0, 0, 0};
    reset_dut();
    for (int k = 0; k < 11; k++) begin
      tick();
      drive(tv[k].re, tv[k].ra, tv[k].r1, tv[k].x1, tv[k].y1, tv[k].r2, tv[k].x2, tv[k].y2);
      #4;
      chk("tbl_ack1", bus.p1_ack, tv[k].a1);
      chk("tbl_ack2", bus.p2_ack, tv[k].a2);
      chk("tbl_addr", bus.bram_addr, tv[k].addr);
      if (k > 0) begin
        chk("tbl_rvalid1", bus.p1_rvalid, tv[k-1].a1);
        chk("tbl_rvalid2", bus.p2_rvalid, tv[k-1].a2);
        if (tv[k-1].a1) chk("tbl_rdata1", bus.p1_rdata, exp_data(tv[k-1].x1, tv[k-1].y1));
        if (tv[k-1].a2) chk("tbl_rdata2", bus.p2_rdata, exp_data(tv[k-1].x2, tv[k-1].y2));
      end
    end
    // both held: acks alternate P1,P2,P1,P2 with rvalids one cycle behind
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      tick();
      drive(0, 0, k < 4, 10, 10, k < 4, 20, 20);
      #4;
      chk("alt_ack1", bus.p1_ack, k < 4 && k % 2 == 0);
      chk("alt_ack2", bus.p2_ack, k < 4 && k % 2 == 1);
      chk("alt_rvalid1", bus.p1_rvalid, k > 0 && k % 2 == 1);
      chk("alt_rvalid2", bus.p2_rvalid, k > 0 && k % 2 == 0);
    end
    chk("alt_rdata1", bus.p1_rdata, exp_data(10, 10));
    chk("alt_rdata2", bus.p2_rdata, exp_data(20, 20));
    // renderer holds the port until P2 starves
    reset_dut();
    for (int c = 1; c <= 1024; c++) begin
      tick();
      drive(1, 500, 0, 0, 0, 1, 5, 5);
      #4;
      if (bus.p2_ack || bus.bram_addr != 17'd500) chk("starve_hold", {bus.p2_ack, bus.bram_addr}, 500);
      if (c == 1023) chk("starve_before", bus.starve_flag, 0);
      if (c == 1024) chk("starve_set", bus.starve_flag, 2);
    end
    tick();
    drive(0, 0, 0, 0, 0, 1, 5, 5);
    #4;
    chk("starve_served_ack", bus.p2_ack, 1);
    chk("starve_served_addr", bus.bram_addr, 1605);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk("starve_rvalid", bus.p2_rvalid, 1);
    chk("starve_sticky", bus.starve_flag, 2);
    // reset right after an ack flushes the pending result
    reset_dut();
    tick();
    drive(0, 0, 1, 15, 125, 0, 0, 0);
    #4;
    chk("rstmid_ack", bus.p1_ack, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #4;
    chk("rstmid_rvalid", bus.p1_rvalid, 0);
    chk("rstmid_outs", {bus.p1_ack, bus.p2_ack, bus.p2_rvalid, bus.p1_rdata, bus.p2_rdata, bus.starve_flag}, 0);
    chk("rstmid_addr", bus.bram_addr, 0);
    tick();
    rst = 1'b1;
    tick();
    drive(0, 0, 1, 3, 3, 1, 4, 4);
    #4;
    chk("rstmid_p1_first", {bus.p1_ack, bus.p2_ack}, 2);
    // randomized traffic against the reference model
    reset_dut();
    lg = 1;
    for (int j = 0; j < 2; j++) begin
      pv[j] = 0; pd[j] = 0; held[j] = 0; wcnt[j] = 0; mflag[j] = 0; rq[j] = 0; acked[j] = 0;
      rx[j] = 0; ry[j] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      tick();
      re = $urandom_range(0, 9) < 6;
      ra = $urandom_range(0, 131071);
      for (int j = 0; j < 2; j++) begin
        if (acked[j] || !rq[j]) begin
          rq[j] = acked[j] ? $urandom_range(0, 1) == 1 : $urandom_range(0, 2) == 0;
          rx[j] = $urandom_range(0, 399);
          ry[j] = $urandom_range(0, 299);
        end else if ($urandom_range(0, 15) == 0) rq[j] = 0;
      end
      drive(re, ra, rq[0], rx[0], ry[0], rq[1], rx[1], ry[1]);
      #4;
      for (int j = 0; j < 2; j++) el[j] = rq[j] && (!re || is_oob(rx[j], ry[j]));
      win = -1;
      if (el[0] && el[1]) win = 1 - lg;
      else if (el[0]) win = 0;
      else if (el[1]) win = 1;
      eaddr = re ? ra : win >= 0 ? qaddr(rx[win], ry[win]) : 0;
      chk("rnd_ack1", bus.p1_ack, win == 0);
      chk("rnd_ack2", bus.p2_ack, win == 1);
      chk("rnd_addr", bus.bram_addr, eaddr);
      chk("rnd_rvalid1", bus.p1_rvalid, pv[0]);
      chk("rnd_rvalid2", bus.p2_rvalid, pv[1]);
      chk("rnd_rdata1", bus.p1_rdata, pv[0] ? pd[0] : held[0]);
      chk("rnd_rdata2", bus.p2_rdata, pv[1] ? pd[1] : held[1]);
      chk("rnd_starve", bus.starve_flag, {mflag[1], mflag[0]});
      for (int j = 0; j < 2; j++) begin
        if (pv[j]) held[j] = pd[j];
        pv[j] = win == j;
        pd[j] = exp_data(rx[j], ry[j]);
        acked[j] = win == j;
        if (rq[j] && win != j) begin
          if (wcnt[j] < 1023) wcnt[j]++;
          if (wcnt[j] >= 1023) mflag[j] = 1;
        end else wcnt[j] = 0;
      end
      if (win >= 0) lg = win;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
